// File: rtl/tama_input_conditioner.sv
// Front-end conditioning for the tamagotchi top: synchronizes and debounces raw buttons,
// the test button and sensors, and produces press/auto-repeat pulses, sensor change pulses and test_mode.
module tama_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES   = 32'd500000,
    parameter int unsigned REPEAT_DELAY      = 32'd25000000,
    parameter int unsigned REPEAT_PERIOD     = 32'd10000000,
    parameter int unsigned LONG_PRESS_CYCLES = 32'd100000000,
    parameter logic [3:0]  REPEAT_MASK       = 4'b0011,
    parameter bit          BTN_ACTIVE_LOW    = 1'b1,
    parameter bit          SNS_ACTIVE_LOW    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    input  logic       test_raw,
    input  logic [2:0] sns_raw,
    output logic [3:0] btn_level,
    output logic [3:0] btn_pulse,
    output logic [2:0] sns_level,
    output logic [2:0] sns_change,
    output logic       test_mode
);

    localparam int unsigned NIN     = 32'd8;
    localparam int unsigned DBW     = $clog2(DEBOUNCE_CYCLES) + 32'd1;
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPW     = $clog2(REP_MAX) + 32'd1;
    localparam int unsigned LPW     = $clog2(LONG_PRESS_CYCLES) + 32'd1;

    localparam logic [DBW-1:0] DB_ZERO       = DBW'(32'd0);
    localparam logic [DBW-1:0] DB_ONE        = DBW'(32'd1);
    localparam logic [DBW-1:0] DB_LAST       = DBW'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [RPW-1:0] RP_ZERO       = RPW'(32'd0);
    localparam logic [RPW-1:0] RP_ONE        = RPW'(32'd1);
    localparam logic [RPW-1:0] RP_FIRST_LAST = RPW'(REPEAT_DELAY - 32'd1);
    localparam logic [RPW-1:0] RP_NEXT_LAST  = RPW'(REPEAT_PERIOD - 32'd1);
    localparam logic [LPW-1:0] LP_ZERO       = LPW'(32'd0);
    localparam logic [LPW-1:0] LP_ONE        = LPW'(32'd1);
    localparam logic [LPW-1:0] LP_LAST       = LPW'(LONG_PRESS_CYCLES - 32'd1);

    // Idle raw level per input; XOR with it turns every input active-high.
    // Bit map: [3:0] buttons, [4] test button, [7:5] sensors.
    localparam logic [NIN-1:0] RAW_IDLE = {{3{SNS_ACTIVE_LOW}}, BTN_ACTIVE_LOW, {4{BTN_ACTIVE_LOW}}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNT    = 2'd1,
        ST_WAIT_REL = 2'd2
    } tm_state_e;

    logic [NIN-1:0] raw_s;
    logic [NIN-1:0] norm_s;
    logic [NIN-1:0] sync1_q;
    logic [NIN-1:0] sync2_q;
    logic [NIN-1:0] deb_q;
    logic [NIN-1:0] deb_d;
    logic [DBW-1:0] db_cnt_q [NIN];
    logic [DBW-1:0] db_cnt_d [NIN];

    logic [RPW-1:0] hold_q [4];
    logic [RPW-1:0] hold_d [4];
    logic [3:0]     rep_on_q;
    logic [3:0]     rep_on_d;
    logic [3:0]     rep_fire_s;
    logic [3:0]     pulse_raw_s;
    logic [3:0]     pulse_q;
    logic [3:0]     pulse_d;
    logic [2:0]     chg_q;
    logic [2:0]     chg_d;

    tm_state_e      state_q;
    tm_state_e      state_d;
    logic [LPW-1:0] lp_cnt_q;
    logic [LPW-1:0] lp_cnt_d;
    logic           test_lvl_s;
    logic           toggle_s;
    logic           test_mode_q;
    logic           test_mode_d;

    assign raw_s      = {sns_raw, test_raw, btn_raw};
    assign norm_s     = sync2_q ^ RAW_IDLE;
    assign test_lvl_s = deb_q[4];

    // Debounce: a level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < int'(NIN); i++) begin
            db_cnt_d[i] = DB_ZERO;
            if (norm_s[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    deb_d[i]    = norm_s[i];
                    db_cnt_d[i] = DB_ZERO;
                end else begin
                    deb_d[i]    = deb_q[i];
                    db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
                end
            end else begin
                deb_d[i]    = deb_q[i];
                db_cnt_d[i] = DB_ZERO;
            end
        end
    end

    // Auto-repeat hold counters; a release or a fresh press restarts the count from zero.
    always_comb begin
        rep_fire_s = 4'b0000;
        rep_on_d   = rep_on_q;
        for (int i = 0; i < 4; i++) begin
            hold_d[i] = hold_q[i];
            if (!REPEAT_MASK[i] || !deb_d[i] || !deb_q[i]) begin
                hold_d[i]   = RP_ZERO;
                rep_on_d[i] = 1'b0;
            end else if (hold_q[i] == (rep_on_q[i] ? RP_NEXT_LAST : RP_FIRST_LAST)) begin
                hold_d[i]     = RP_ZERO;
                rep_on_d[i]   = 1'b1;
                rep_fire_s[i] = 1'b1;
            end else begin
                hold_d[i] = hold_q[i] + RP_ONE;
            end
        end
    end

    // Press/repeat pulses with pairwise conflict suppression; sensor edge pulses.
    always_comb begin
        pulse_raw_s = (deb_d[3:0] & ~deb_q[3:0]) | rep_fire_s;
        if (&pulse_raw_s[1:0]) begin
            pulse_d[1:0] = 2'b00;
        end else begin
            pulse_d[1:0] = pulse_raw_s[1:0];
        end
        if (&pulse_raw_s[3:2]) begin
            pulse_d[3:2] = 2'b00;
        end else begin
            pulse_d[3:2] = pulse_raw_s[3:2];
        end
        chg_d = deb_d[7:5] ^ deb_q[7:5];
    end

    // Synchronizers, debounce state, repeat counters and registered pulse outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= RAW_IDLE;
            sync2_q  <= RAW_IDLE;
            deb_q    <= {NIN{1'b0}};
            for (int i = 0; i < int'(NIN); i++) begin
                db_cnt_q[i] <= DB_ZERO;
            end
            for (int i = 0; i < 4; i++) begin
                hold_q[i] <= RP_ZERO;
            end
            rep_on_q <= 4'b0000;
            pulse_q  <= 4'b0000;
            chg_q    <= 3'b000;
        end else begin
            sync1_q  <= raw_s;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            for (int i = 0; i < int'(NIN); i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            for (int i = 0; i < 4; i++) begin
                hold_q[i] <= hold_d[i];
            end
            rep_on_q <= rep_on_d;
            pulse_q  <= pulse_d;
            chg_q    <= chg_d;
        end
    end

    // Test-mode FSM state register and the flag it toggles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            lp_cnt_q    <= LP_ZERO;
            test_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lp_cnt_q    <= lp_cnt_d;
            test_mode_q <= test_mode_d;
        end
    end

    // Test-mode FSM next state; WAIT_REL guarantees one toggle per hold.
    always_comb begin
        state_d  = state_q;
        lp_cnt_d = lp_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (test_lvl_s) begin
                    state_d  = ST_COUNT;
                    lp_cnt_d = LP_ONE;
                end else begin
                    state_d  = ST_IDLE;
                    lp_cnt_d = LP_ZERO;
                end
            end
            ST_COUNT: begin
                if (!test_lvl_s) begin
                    state_d  = ST_IDLE;
                    lp_cnt_d = LP_ZERO;
                end else if (lp_cnt_q == LP_LAST) begin
                    state_d  = ST_WAIT_REL;
                    lp_cnt_d = LP_ZERO;
                end else begin
                    state_d  = ST_COUNT;
                    lp_cnt_d = lp_cnt_q + LP_ONE;
                end
            end
            ST_WAIT_REL: begin
                lp_cnt_d = LP_ZERO;
                if (!test_lvl_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_REL;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                lp_cnt_d = LP_ZERO;
            end
        endcase
    end

    // Test-mode FSM output: toggle on the cycle the hold reaches the long-press length.
    always_comb begin
        if ((state_q == ST_COUNT) && test_lvl_s && (lp_cnt_q == LP_LAST)) begin
            toggle_s = 1'b1;
        end else begin
            toggle_s = 1'b0;
        end
        test_mode_d = test_mode_q ^ toggle_s;
    end

    assign btn_level  = deb_q[3:0];
    assign sns_level  = deb_q[7:5];
    assign btn_pulse  = pulse_q;
    assign sns_change = chg_q;
    assign test_mode  = test_mode_q;

endmodule

// File: tb/tb_tama_input_conditioner.sv
// Self-checking bench for tama_input_conditioner with short debounce/repeat/long-press timings,
// compared against a sliding-window behavioural model plus fixed expected cycle numbers.
module tb_tama_input_conditioner;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam int LP = 30;
    localparam logic [3:0] RMASK = 4'b0011;
    localparam logic [7:0] FLIP  = 8'b0001_1111;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic       test_raw;
    logic [2:0] sns_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_pulse;
    logic [2:0] sns_level;
    logic [2:0] sns_change;
    logic       test_mode;
    logic [14:0] obs;

    always #5 clk = ~clk;

    tama_input_conditioner #(
        .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .LONG_PRESS_CYCLES(LP)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .test_raw(test_raw), .sns_raw(sns_raw),
        .btn_level(btn_level), .btn_pulse(btn_pulse), .sns_level(sns_level),
        .sns_change(sns_change), .test_mode(test_mode)
    );

    assign obs = {test_mode, sns_change, sns_level, btn_pulse, btn_level};

    int checks = 0;
    int errors = 0;

    // Model state: active-high sample history, levels, press edge numbers, test flag.
    logic [7:0]  m_lvl;
    logic [7:0]  m_hist[$];
    int          m_press[4];
    int          m_tpress;
    logic        m_tmode;
    int          m_n;
    logic [14:0] exp_v;

    task automatic model_reset();
        m_lvl = 8'h00;
        m_hist = {};
        for (int k = 0; k < DB + 2; k++) m_hist.push_back(8'h00);
        for (int k = 0; k < 4; k++) m_press[k] = -100000;
        m_tpress = -100000;
        m_tmode = 1'b0;
        m_n = 0;
        exp_v = 15'h0000;
    endtask

    // One clock edge: a level flips when the DB samples seen through the 2-stage delay all disagree with it.
    task automatic step();
        logic [7:0] nrm;
        logic [7:0] nlvl;
        logic [3:0] pls;
        int d;
        bit alldiff;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            m_n++;
            nrm = {sns_raw, test_raw, btn_raw} ^ FLIP;
            m_hist.push_back(nrm);
            void'(m_hist.pop_front());
            nlvl = m_lvl;
            for (int i = 0; i < 8; i++) begin
                alldiff = 1'b1;
                for (int k = 0; k < DB; k++) if (m_hist[k][i] == m_lvl[i]) alldiff = 1'b0;
                if (alldiff) nlvl[i] = ~m_lvl[i];
            end
            pls = 4'h0;
            for (int i = 0; i < 4; i++) begin
                if (nlvl[i] && !m_lvl[i]) begin
                    m_press[i] = m_n;
                    pls[i] = 1'b1;
                end else if (nlvl[i] && m_lvl[i] && RMASK[i]) begin
                    d = m_n - m_press[i];
                    if (d == RD || (d > RD && ((d - RD) % RP) == 0)) pls[i] = 1'b1;
                end
            end
            if (pls[1:0] == 2'b11) pls[1:0] = 2'b00;
            if (pls[3:2] == 2'b11) pls[3:2] = 2'b00;
            if (m_lvl[4] && (m_n - m_tpress) == LP) m_tmode = ~m_tmode;
            if (nlvl[4] && !m_lvl[4]) m_tpress = m_n;
            exp_v = {m_tmode, nlvl[7:5] ^ m_lvl[7:5], nlvl[7:5], pls, nlvl[3:0]};
            m_lvl = nlvl;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_raw = 4'hF; test_raw = 1'b1; sns_raw = 3'b000;
        #1 rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== 15'h0000) begin errors++; $display("FAIL reset_state got=%h exp=0000", obs); end
        for (int c = 1; c <= 3; c++) begin
            step();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL reset_hold c=%0d got=%h exp=%h", c, obs, exp_v); end
        end
        rst = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL reset_idle c=%0d got=%h exp=%h", c, obs, exp_v); end
        end
    endtask

    task automatic test_clean_press();
        int npulse = 0;
        int pcyc = -1;
        btn_raw[2] = 1'b0;
        for (int c = 1; c <= 55; c++) begin
            if (c == 41) btn_raw[2] = 1'b1;
            step();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL clean_press c=%0d got=%h exp=%h", c, obs, exp_v); end
            if (btn_pulse[2]) begin npulse++; pcyc = c; end
            if (c == 6) begin
                checks++;
                if (btn_level[2] !== 1'b1) begin errors++; $display("FAIL clean_level got=%b exp=1", btn_level[2]); end
            end
        end
        checks++;
        if (npulse != 1 || pcyc != 6) begin
            errors++; $display("FAIL clean_pulse got=%0d@%0d exp=1@6", npulse, pcyc);
        end
    endtask

    task automatic test_bounce();
        int seen = 0;
        for (int c = 1; c <= 32; c++) begin
            if (c <= 20) btn_raw[0] = (((c - 1) / 2) % 2 == 0) ? 1'b0 : 1'b1;
            else btn_raw[0] = 1'b1;
            step();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL bounce c=%0d got=%h exp=%h", c, obs, exp_v); end
            if (btn_level[0] || btn_pulse[0]) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL bounce_quiet got=%0d exp=0", seen); end
    endtask

    task automatic test_auto_repeat();
        int exp_cyc[6] = '{6, 26, 34, 42, 50, 58};
        int got[$];
        int fall = -1;
        logic prev = 1'b0;
        btn_raw[0] = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            if (c == 61) btn_raw[0] = 1'b1;
            step();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL repeat c=%0d got=%h exp=%h", c, obs, exp_v); end
            if (btn_pulse[0]) got.push_back(c);
            if (prev && !btn_level[0] && fall < 0) fall = c;
            prev = btn_level[0];
        end
        checks++;
        if (got.size() != 6) begin
            errors++; $display("FAIL repeat_count got=%0d exp=6", got.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (got[k] != exp_cyc[k]) begin errors++; $display("FAIL repeat_cyc%0d got=%0d exp=%0d", k, got[k], exp_cyc[k]); end
            end
        end
        checks++;
        if (fall != 66) begin errors++; $display("FAIL repeat_fall got=%0d exp=66", fall); end
    endtask

    task automatic test_conflict();
        int np = 0;
        int c2 = -1;
        int c3 = -1;
        btn_raw[3:2] = 2'b00;
        for (int c = 1; c <= 30; c++) begin
            if (c == 16) btn_raw[3:2] = 2'b11;
            step();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL conflict c=%0d got=%h exp=%h", c, obs, exp_v); end
            if (btn_pulse[2] || btn_pulse[3]) np++;
            if (c == 6) begin
                checks++;
                if (btn_level[3:2] !== 2'b11) begin errors++; $display("FAIL conflict_level got=%b exp=11", btn_level[3:2]); end
            end
        end
        checks++;
        if (np != 0) begin errors++; $display("FAIL conflict_masked got=%0d exp=0", np); end
        btn_raw[2] = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            if (c == 4) btn_raw[3] = 1'b0;
            if (c == 20) btn_raw[3:2] = 2'b11;
            step();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL stagger c=%0d got=%h exp=%h", c, obs, exp_v); end
            if (btn_pulse[2]) c2 = c;
            if (btn_pulse[3]) c3 = c;
        end
        checks++;
        if (c2 != 6 || c3 != 9) begin errors++; $display("FAIL stagger_pulses got=%0d,%0d exp=6,9", c2, c3); end
    endtask

    task automatic test_test_mode();
        int lens[3] = '{50, 10, 50};
        int tcyc = -1;
        int toggles = 0;
        logic prev;
        logic want;
        prev = test_mode;
        for (int ph = 0; ph < 3; ph++) begin
            test_raw = 1'b0;
            for (int c = 1; c <= lens[ph] + 20; c++) begin
                if (c == lens[ph] + 1) test_raw = 1'b1;
                step();
                checks++;
                if (obs !== exp_v) begin errors++; $display("FAIL test_mode ph=%0d c=%0d got=%h exp=%h", ph, c, obs, exp_v); end
                if (ph == 0 && test_mode && tcyc < 0) tcyc = c;
                if (test_mode !== prev) toggles++;
                prev = test_mode;
            end
            want = (ph == 2) ? 1'b0 : 1'b1;
            checks++;
            if (test_mode !== want) begin errors++; $display("FAIL test_flag ph=%0d got=%b exp=%b", ph, test_mode, want); end
        end
        checks++;
        if (tcyc != 36 || toggles != 2) begin errors++; $display("FAIL test_toggle got=%0d/%0d exp=36/2", tcyc, toggles); end
    endtask

    task automatic test_sensor_reset();
        int cc = -1;
        int nc = 0;
        int pc = -1;
        sns_raw[2] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL sensor c=%0d got=%h exp=%h", c, obs, exp_v); end
            if (sns_change[2]) begin nc++; cc = c; end
        end
        checks++;
        if (nc != 1 || cc != 6 || sns_level[2] !== 1'b1) begin
            errors++; $display("FAIL sensor_edge got=%0d@%0d lvl=%b exp=1@6 lvl=1", nc, cc, sns_level[2]);
        end
        btn_raw[1] = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            step();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL hold1 c=%0d got=%h exp=%h", c, obs, exp_v); end
        end
        rst = 1'b0;
        model_reset();
        #2;
        checks++;
        if (obs !== 15'h0000) begin errors++; $display("FAIL async_clear got=%h exp=0000", obs); end
        for (int c = 1; c <= 3; c++) begin
            step();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL in_reset c=%0d got=%h exp=%h", c, obs, exp_v); end
        end
        rst = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL post_reset c=%0d got=%h exp=%h", c, obs, exp_v); end
            if (btn_pulse[1] && pc < 0) pc = c;
        end
        checks++;
        if (pc != 6) begin errors++; $display("FAIL held_through_reset got=%0d exp=6", pc); end
        btn_raw[1] = 1'b1;
        sns_raw[2] = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            step();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL release c=%0d got=%h exp=%h", c, obs, exp_v); end
        end
    endtask

    task automatic test_random();
        int rate = 3;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) rate = ($urandom_range(0, 2) == 0) ? 3 : 40;
            for (int i = 0; i < 4; i++) if ($urandom_range(1, rate) == 1) btn_raw[i] = ~btn_raw[i];
            if ($urandom_range(1, rate) == 1) test_raw = ~test_raw;
            for (int i = 0; i < 3; i++) if ($urandom_range(1, rate) == 1) sns_raw[i] = ~sns_raw[i];
            if (!rst) begin
                rst = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                rst = 1'b0;
                model_reset();
                #1;
                checks++;
                if (obs !== 15'h0000) begin errors++; $display("FAIL rand_reset c=%0d got=%h exp=0000", c, obs); end
            end
            step();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL random c=%0d got=%h exp=%h", c, obs, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_conflict();
        test_test_mode();
        test_sensor_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
